multicycle_control: RTL and testbench

Parametrised multi-cycle control FSM for the RISC-V RV32I core, replacing the single-cycle combinational decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and stretches memory phases for configurable RAM latency. It adds a ready/timeout handshake on MMIO accesses and traps on illegal opcodes and unmapped addresses. It sits between the instruction register, the ALU, the data RAM and the MMIO bus.

---
 rtl/multicycle_control.sv | 249 ++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB/TRAP with
// stretched ROM/RAM phases, MMIO ready/timeout handshake and traps.
// Ports: clk, rst (sync, active-high); instruction, alu_result,
//   branch_taken, io_ready in; ir_write, pc_write, pc_src, alu_op,
//   alu_src, sftmd, mem_read/write, io_read/write, mem_to_reg,
//   reg_write, retired, trap, trap_cause out.
module multicycle_control #(
   parameter int unsigned FETCH_WAIT = 1,
   parameter int unsigned MEM_WAIT   = 1,
   parameter logic [31:0] IO_BASE    = 32'hFFFFFC00,
   parameter logic [31:0] RAM_LIMIT  = 32'h00010000,
   parameter int unsigned IO_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instruction,
   input  logic [31:0] alu_result,
   input  logic        branch_taken,
   input  logic        io_ready,
   output logic        ir_write,
   output logic        pc_write,
   output logic [1:0]  pc_src,
   output logic [3:0]  alu_op,
   output logic        alu_src,
   output logic        sftmd,
   output logic        mem_read,
   output logic        mem_write,
   output logic        io_read,
   output logic        io_write,
   output logic        mem_to_reg,
   output logic        reg_write,
   output logic        retired,
   output logic        trap,
   output logic [1:0]  trap_cause
);

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
   } state_t;

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_LD   = 7'b0000011;
   localparam logic [6:0] OP_ST   = 7'b0100011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_LUI  = 7'b0110111;
   localparam logic [6:0] OP_AUI  = 7'b0010111;

   localparam logic [15:0] C_FW = 16'(FETCH_WAIT - 1);
   localparam logic [15:0] C_MW = 16'(MEM_WAIT - 1);
   localparam logic [15:0] C_TO = 16'(IO_TIMEOUT - 1);

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_cnt;
   logic [1:0]  r_cause;
   logic [1:0]  w_cause;

   logic [6:0]  w_opc;
   logic [2:0]  w_f3;
   logic [6:0]  w_f7;
   logic        w_is_r, w_is_i, w_is_ld, w_is_st, w_is_br;
   logic        w_is_jal, w_is_jalr, w_is_lui, w_is_aui;
   logic        w_r_legal, w_legal;
   logic        w_is_io, w_is_ram, w_unmapped;
   logic [3:0]  w_alu_op;
   logic        w_alu_src, w_sft;
   logic        w_unused;

   assign w_opc = instruction[6:0];
   assign w_f3  = instruction[14:12];
   assign w_f7  = instruction[31:25];
   assign w_unused = ^{instruction[24:15], instruction[11:7]};

   assign w_is_r    = (w_opc == OP_R);
   assign w_is_i    = (w_opc == OP_I);
   assign w_is_ld   = (w_opc == OP_LD);
   assign w_is_st   = (w_opc == OP_ST);
   assign w_is_br   = (w_opc == OP_BR);
   assign w_is_jal  = (w_opc == OP_JAL);
   assign w_is_jalr = (w_opc == OP_JALR);
   assign w_is_lui  = (w_opc == OP_LUI);
   assign w_is_aui  = (w_opc == OP_AUI);

   // Legal R forms: func7=0 with any func3, func7=0100000 only for sub/sra.
   assign w_r_legal = (w_f7 == 7'b0000000)
                    | ((w_f7 == 7'b0100000)
                       & ((w_f3 == 3'b000) | (w_f3 == 3'b101)));
   assign w_legal = (w_is_r & w_r_legal) | w_is_i | w_is_ld | w_is_st
                  | w_is_br | w_is_jal | w_is_jalr | w_is_lui | w_is_aui;

   // MMIO window is checked first so it wins if the two ever overlap.
   assign w_is_io    = (alu_result >= IO_BASE);
   assign w_is_ram   = ~w_is_io & (alu_result < RAM_LIMIT);
   assign w_unmapped = ~w_is_io & ~w_is_ram;

   always_comb begin
      w_alu_op = 4'b0000;
      w_sft    = 1'b0;
      if (w_is_r | w_is_i) begin
         case (w_f3)
            3'b000: w_alu_op = (w_is_r & instruction[30]) ? 4'b0001 : 4'b0000;
            3'b001: begin w_alu_op = 4'b0101; w_sft = 1'b1; end
            3'b010: w_alu_op = 4'b1000;
            3'b011: w_alu_op = 4'b1001;
            3'b100: w_alu_op = 4'b0010;
            3'b101: begin
               w_alu_op = instruction[30] ? 4'b0111 : 4'b0110;
               w_sft    = 1'b1;
            end
            3'b110: w_alu_op = 4'b0011;
            3'b111: w_alu_op = 4'b0100;
         endcase
      end else if (w_is_br) begin
         w_alu_op = 4'b0001;
      end else if (w_is_lui) begin
         w_alu_op = 4'b1010;
      end else if (w_is_aui) begin
         w_alu_op = 4'b1011;
      end
   end

   assign w_alu_src = ~(w_is_r | w_is_br);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_FETCH;
         r_cnt   <= 16'd0;
         r_cause <= 2'd0;
      end else begin
         r_state <= w_next;
         r_cause <= w_cause;
         if (w_next != r_state)
            r_cnt <= 16'd0;
         else if (r_state != S_TRAP)
            r_cnt <= r_cnt + 16'd1;
      end
   end

   always_comb begin
      w_next  = r_state;
      w_cause = r_cause;
      unique case (r_state)
         S_FETCH:
            if (r_cnt == C_FW) w_next = S_DECODE;
         S_DECODE:
            if (!w_legal) begin
               w_next  = S_TRAP;
               w_cause = 2'd1;
            end else begin
               w_next = S_EXEC;
            end
         S_EXEC:
            if (w_is_br)
               w_next = S_FETCH;
            else if (w_is_ld | w_is_st)
               w_next = S_MEM;
            else
               w_next = S_WB;
         S_MEM:
            if (w_unmapped) begin
               w_next  = S_TRAP;
               w_cause = 2'd2;
            end else if (w_is_io) begin
               // A ready on the last allowed cycle still counts as success.
               if (io_ready) begin
                  w_next = S_WB;
               end else if (r_cnt == C_TO) begin
                  w_next  = S_TRAP;
                  w_cause = 2'd3;
               end
            end else if (r_cnt == C_MW) begin
               w_next = S_WB;
            end
         S_WB:
            w_next = S_FETCH;
         S_TRAP:
            w_next = S_TRAP;
         default:
            w_next = S_FETCH;
      endcase
   end

   // ALU controls stay valid through MEM and WB so the address and the
   // writeback value remain stable while those phases last.
   always_comb begin
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'd0;
      alu_op     = 4'b0000;
      alu_src    = 1'b0;
      sftmd      = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      io_read    = 1'b0;
      io_write   = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      retired    = 1'b0;
      trap       = 1'b0;
      trap_cause = 2'd0;
      if (!rst) begin
         unique case (r_state)
            S_FETCH:
               ir_write = (r_cnt == C_FW);
            S_EXEC: begin
               alu_op  = w_alu_op;
               alu_src = w_alu_src;
               sftmd   = w_sft;
               if (w_is_br) begin
                  pc_write = 1'b1;
                  pc_src   = branch_taken ? 2'd1 : 2'd0;
                  retired  = 1'b1;
               end
            end
            S_MEM: begin
               alu_op  = w_alu_op;
               alu_src = w_alu_src;
               sftmd   = w_sft;
               if (w_is_io) begin
                  io_read  = w_is_ld;
                  io_write = w_is_st;
               end else if (w_is_ram) begin
                  mem_read  = w_is_ld;
                  mem_write = w_is_st;
               end
            end
            S_WB: begin
               alu_op     = w_alu_op;
               alu_src    = w_alu_src;
               sftmd      = w_sft;
               pc_write   = 1'b1;
               pc_src     = w_is_jal ? 2'd2 : (w_is_jalr ? 2'd3 : 2'd0);
               reg_write  = ~w_is_st;
               mem_to_reg = w_is_ld;
               retired    = 1'b1;
            end
            S_TRAP: begin
               trap       = 1'b1;
               trap_cause = r_cause;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomised bench for multicycle_control: a per-instruction phase model
// builds the expected output trace which is compared cycle by cycle.
module tb_multicycle_control;

   localparam int FW = 2;
   localparam int MW = 3;
   localparam int TO = 8;
   localparam logic [31:0] IOB  = 32'hFFFFFC00;
   localparam logic [31:0] RLIM = 32'h00010000;

   localparam logic [19:0] V_IRW = 20'h80000;
   localparam logic [19:0] V_PCW = 20'h40000;
   localparam logic [19:0] V_MR  = 20'h00200;
   localparam logic [19:0] V_MWR = 20'h00100;
   localparam logic [19:0] V_IOR = 20'h00080;
   localparam logic [19:0] V_IOW = 20'h00040;
   localparam logic [19:0] V_M2R = 20'h00020;
   localparam logic [19:0] V_RW  = 20'h00010;
   localparam logic [19:0] V_RET = 20'h00008;
   localparam logic [19:0] V_TRP = 20'h00004;
   localparam logic [19:0] M_ALL = 20'hFFFFF;
   localparam logic [19:0] M_ALU = 20'h0FC00;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instruction;
   logic [31:0] alu_result;
   logic        branch_taken;
   logic        io_ready;
   logic        ir_write, pc_write, alu_src, sftmd;
   logic [1:0]  pc_src, trap_cause;
   logic [3:0]  alu_op;
   logic        mem_read, mem_write, io_read, io_write;
   logic        mem_to_reg, reg_write, retired, trap;

   multicycle_control #(
      .FETCH_WAIT(FW), .MEM_WAIT(MW), .IO_BASE(IOB),
      .RAM_LIMIT(RLIM), .IO_TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst), .instruction(instruction),
      .alu_result(alu_result), .branch_taken(branch_taken),
      .io_ready(io_ready), .ir_write(ir_write), .pc_write(pc_write),
      .pc_src(pc_src), .alu_op(alu_op), .alu_src(alu_src),
      .sftmd(sftmd), .mem_read(mem_read), .mem_write(mem_write),
      .io_read(io_read), .io_write(io_write),
      .mem_to_reg(mem_to_reg), .reg_write(reg_write),
      .retired(retired), .trap(trap), .trap_cause(trap_cause)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [19:0] v;
      logic [19:0] m;
      logic        rdy;
      string       tag;
   } step_t;

   step_t q[$];
   int n_tests = 0;
   int n_fail  = 0;
   logic [3:0] op_tbl [8] = '{4'h0, 4'h5, 4'h8, 4'h9,
                              4'h2, 4'h6, 4'h3, 4'h4};
   logic [6:0] bad_ops [4] = '{7'b1110011, 7'b0001111,
                               7'b0000000, 7'b1111111};

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [19:0] obs();
      return {ir_write, pc_write, pc_src, alu_op, alu_src, sftmd,
              mem_read, mem_write, io_read, io_write, mem_to_reg,
              reg_write, retired, trap, trap_cause};
   endfunction

   function automatic logic legal(input logic [31:0] x);
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      op = x[6:0];
      f3 = x[14:12];
      f7 = x[31:25];
      if (op == 7'b0110011)
         return (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      return op inside {7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                        7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
   endfunction

   // {alu_op, alu_src, sftmd} expected in EXEC
   function automatic logic [5:0] alu_fields(input logic [31:0] x);
      logic [6:0] op;
      logic [2:0] f3;
      logic [3:0] a;
      op = x[6:0];
      f3 = x[14:12];
      if (op == 7'b0110011 || op == 7'b0010011) begin
         a = op_tbl[f3];
         if (x[30] && (f3 == 3'd5 || (f3 == 3'd0 && op == 7'b0110011)))
            a = a + 4'd1;
         return {a, op == 7'b0010011, f3 == 3'd1 || f3 == 3'd5};
      end
      if (op == 7'b1100011) return {4'h1, 1'b0, 1'b0};
      if (op == 7'b0110111) return {4'hA, 1'b1, 1'b0};
      if (op == 7'b0010111) return {4'hB, 1'b1, 1'b0};
      return {4'h0, 1'b1, 1'b0};
   endfunction

   function automatic void push(input logic [19:0] v, input logic [19:0] m,
                                input logic rdy, input string tag);
      step_t s;
      s.v = v;
      s.m = m;
      s.rdy = rdy;
      s.tag = tag;
      q.push_back(s);
   endfunction

   // Entered and left on a falling edge.
   task automatic do_reset(input string name);
      rst = 1'b1;
      io_ready = 1'($urandom);
      #1;
      check({name, "/rst"}, 32'(obs()), 32'd0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run(input logic [31:0] ins, input logic [31:0] addr,
                      input int k, input logic tk, input int abort_at,
                      input string name);
      logic [6:0]  op;
      logic        ld, st, trapped;
      logic [1:0]  cause;
      logic [19:0] ev, am;
      logic [5:0]  af;
      int          n;
      op = ins[6:0];
      ld = (op == 7'b0000011);
      st = (op == 7'b0100011);
      trapped = 1'b0;
      cause = 2'd0;
      q.delete();
      for (int i = 0; i < FW; i++)
         push((i == FW - 1) ? V_IRW : 20'd0, M_ALL, 1'($urandom), "fetch");
      push(20'd0, M_ALL, 1'($urandom), "decode");
      if (!legal(ins)) begin
         trapped = 1'b1;
         cause = 2'd1;
      end else begin
         af = alu_fields(ins);
         ev = 20'(af) << 10;
         am = (op == 7'b1101111) ? ~M_ALU : M_ALL;
         if (op == 7'b1100011) begin
            push(ev | V_PCW | (tk ? 20'h10000 : 20'd0) | V_RET, M_ALL,
                 1'($urandom), "exec");
         end else begin
            push(ev, am, 1'($urandom), "exec");
            if (ld || st) begin
               if (addr >= IOB) begin
                  n = (k >= 1 && k <= TO) ? k : TO;
                  for (int j = 0; j < n; j++)
                     push(ld ? V_IOR : V_IOW, ~M_ALU, k >= 1 && j == k - 1,
                          "mmio");
                  if (!(k >= 1 && k <= TO)) begin
                     trapped = 1'b1;
                     cause = 2'd3;
                  end
               end else if (addr < RLIM) begin
                  for (int j = 0; j < MW; j++)
                     push(ld ? V_MR : V_MWR, ~M_ALU, 1'($urandom), "ram");
               end else begin
                  push(20'd0, ~M_ALU, 1'($urandom), "unmap");
                  trapped = 1'b1;
                  cause = 2'd2;
               end
            end
            if (!trapped) begin
               ev = V_PCW | V_RET;
               if (op == 7'b1101111) ev = ev | 20'h20000;
               if (op == 7'b1100111) ev = ev | 20'h30000;
               if (!st) ev = ev | V_RW;
               if (ld) ev = ev | V_M2R;
               push(ev, ~M_ALU, 1'($urandom), "wb");
            end
         end
      end
      if (trapped) begin
         push(V_TRP | 20'(cause), M_ALL, 1'($urandom), "trap");
         push(V_TRP | 20'(cause), M_ALL, 1'($urandom), "trap");
      end
      instruction = ins;
      alu_result = addr;
      branch_taken = tk;
      foreach (q[i]) begin
         if (i == abort_at) begin
            do_reset({name, "/abort"});
            return;
         end
         io_ready = q[i].rdy;
         #1;
         check($sformatf("%s/%s%0d", name, q[i].tag, i),
               32'(obs() & q[i].m), 32'(q[i].v & q[i].m));
         @(negedge clk);
      end
      if (trapped) do_reset(name);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] b;
      logic [2:0]  f3;
      logic [6:0]  hi;
      int          sel;
      b = $urandom;
      f3 = b[14:12];
      hi = b[31:25];
      sel = $urandom_range(0, 10);
      case (sel)
         0: begin
            hi = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1)
                 ? 7'h20 : 7'h00;
            return {hi, b[24:15], f3, b[11:7], 7'b0110011};
         end
         1: begin
            if ($urandom_range(0, 1) == 1) return {7'h01, b[24:0] & 25'h1FFFF80 | 25'h33};
            return {7'h20, b[24:15], 3'b001, b[11:7], 7'b0110011};
         end
         2: begin
            if (f3 == 3'd5) hi = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            if (f3 == 3'd1) hi = 7'h00;
            return {hi, b[24:15], f3, b[11:7], 7'b0010011};
         end
         3: return {b[31:7], 7'b0000011};
         4: return {b[31:7], 7'b0100011};
         5: return {b[31:7], 7'b1100011};
         6: return {b[31:7], 7'b1101111};
         7: return {b[31:15], 3'b000, b[11:7], 7'b1100111};
         8: return {b[31:7], 7'b0110111};
         9: return {b[31:7], 7'b0010111};
         default: return {b[31:7], bad_ops[$urandom_range(0, 3)]};
      endcase
   endfunction

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 8))
         0: return RLIM - 32'd1;
         1: return RLIM;
         2: return IOB - 32'd1;
         3: return IOB;
         4: return 32'hFFFFFFFF;
         5: return $urandom_range(32'hFFFFFFFF, IOB);
         6: return $urandom_range(IOB - 32'd1, RLIM);
         default: return $urandom_range(RLIM - 32'd1, 0);
      endcase
   endfunction

   initial begin
      rst = 1'b1;
      instruction = 32'd0;
      alu_result = 32'd0;
      branch_taken = 1'b0;
      io_ready = 1'b0;
      @(negedge clk);
      #1;
      check("rst0", 32'(obs()), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run(32'h002081B3, 32'h0, 0, 1'b0, -1, "add");
      run(32'h0000A283, 32'h0000FFFC, 0, 1'b0, -1, "lw_ram");
      run(32'h0050A023, 32'hFFFFFC60, 4, 1'b0, -1, "sw_io4");
      run(32'h0050A023, 32'hFFFFFC60, 0, 1'b0, -1, "sw_tmo");
      run(32'h0000A283, 32'h00010000, 0, 1'b0, -1, "lw_unmap");
      run(32'hFFFFFFFF, 32'h0, 0, 1'b0, -1, "illegal");
      run(32'h00208463, 32'h0, 0, 1'b1, -1, "beq_t");
      run(32'h00208463, 32'h0, 0, 1'b0, -1, "beq_nt");
      run(32'h0050A023, IOB, 0, 1'b0, FW + 2 + 3, "io_abort");
      run(32'h0000A283, RLIM - 32'd1, 0, 1'b0, -1, "ram_top");
      run(32'h0000A283, IOB - 32'd1, 0, 1'b0, -1, "below_io");
      run(32'h0000A283, IOB, 1, 1'b0, -1, "io_k1");
      run(32'h0000A283, 32'hFFFFFFFF, TO, 1'b0, -1, "io_kmax");
      run(32'h002081B3, 32'h0, 0, 1'b0, -1, "add2");

      for (int t = 0; t < 300; t++) begin
         run(rand_instr(), rand_addr(), $urandom_range(0, TO),
             1'($urandom),
             ($urandom_range(0, 9) == 0) ? $urandom_range(0, 14) : -1,
             $sformatf("r%0d", t));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
